// File: rtl/tff_bank_counter_if.sv
//==============================================================================
// Module   : tff_bank_counter_if
// Brief    : Control/data bundle for tff_bank_counter (mode, enables, load, state).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface tff_bank_counter_if #(
    parameter int WIDTH = 4
);
    logic             mode;
    logic [WIDTH-1:0] t;
    logic             up;
    logic             ld;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             tc;

    modport master (
        output mode, t, up, ld, d,
        input  q, tc
    );

    modport slave (
        input  mode, t, up, ld, d,
        output q, tc
    );
endinterface

`default_nettype wire

// File: rtl/tff_bank_counter.sv
//==============================================================================
// Module   : tff_bank_counter
// Brief    : WIDTH-bit T flip-flop bank / modulo-MOD up-down counter with a
//            registered terminal-count pulse. Define TFF_BANK_SAT_EN to make
//            the counter saturate at its limits instead of wrapping.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tff_bank_counter #(
    parameter int WIDTH   = 4,
    parameter int MOD     = 10,
    parameter int RST_VAL = 0
) (
    input  wire                  ck,
    input  wire                  rs,
    tff_bank_counter_if.slave    bus
);

    localparam logic [WIDTH-1:0]   c_MOD_M1 = WIDTH'(MOD - 1);
    localparam logic [WIDTH:0]     c_MOD_W  = (WIDTH + 1)'(MOD);
    localparam logic [2*WIDTH:0]   c_MOD_X  = (2 * WIDTH + 1)'(MOD);
    localparam logic [WIDTH-1:0]   c_RST    = WIDTH'(RST_VAL);
`ifdef TFF_BANK_SAT_EN
    localparam bit                 c_SAT    = 1'b1;
`else
    localparam bit                 c_SAT    = 1'b0;
`endif

    // Restoring reduction: subtract MOD<<k wherever it fits, MSB stage first,
    // so any WIDTH-bit value lands in 0..MOD-1 after WIDTH compare/subtracts.
    function automatic logic [WIDTH-1:0] f_mod(input logic [WIDTH-1:0] val);
        logic [2*WIDTH:0] r;
        r = (2 * WIDTH + 1)'(val);
        for (int k = WIDTH - 1; k >= 0; k--) begin
            if (r >= (c_MOD_X << k)) begin
                r = r - (c_MOD_X << k);
            end
        end
        return WIDTH'(r);
    endfunction

    logic [WIDTH-1:0] r_q;
    logic             r_tc;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_tc_nxt;
    logic             w_oor;
    logic             w_at_top;
    logic             w_at_bot;

    // at_top also covers out-of-range values left behind by toggle mode
    assign w_oor    = ({1'b0, r_q} >= c_MOD_W);
    assign w_at_top = (r_q >= c_MOD_M1);
    assign w_at_bot = (r_q == '0);

    always_comb begin
        w_q_nxt  = r_q;
        w_tc_nxt = 1'b0;
        if (bus.ld) begin
            w_q_nxt = bus.mode ? f_mod(bus.d) : bus.d;
        end else if (!bus.mode) begin
            w_q_nxt = r_q ^ bus.t;
        end else if (bus.t[0]) begin
            if (bus.up) begin
                if (w_at_top) begin
                    w_tc_nxt = 1'b1;
                    w_q_nxt  = c_SAT ? c_MOD_M1 : '0;
                end else begin
                    w_q_nxt  = r_q + WIDTH'(1);
                end
            end else begin
                if (w_oor) begin
                    w_tc_nxt = 1'b1;
                    w_q_nxt  = c_MOD_M1;
                end else if (w_at_bot) begin
                    w_tc_nxt = 1'b1;
                    w_q_nxt  = c_SAT ? '0 : c_MOD_M1;
                end else begin
                    w_q_nxt  = r_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge ck) begin
        if (rs) begin
            r_q  <= c_RST;
            r_tc <= 1'b0;
        end else begin
            r_q  <= w_q_nxt;
            r_tc <= w_tc_nxt;
        end
    end

    assign bus.q  = r_q;
    assign bus.tc = r_tc;

endmodule

`default_nettype wire

// File: tb/tb_tff_bank_counter.sv
//==============================================================================
// Module   : tb_tff_bank_counter
// Brief    : Directed + randomized bench for tff_bank_counter against an
//            integer reference model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_tff_bank_counter;

    localparam int WIDTH   = 4;
    localparam int MOD     = 10;
    localparam int RST_VAL = 0;
`ifdef TFF_BANK_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic ck = 1'b0;
    logic rs;
    always #5 ck = ~ck;

    tff_bank_counter_if #(.WIDTH(WIDTH)) bus ();

    tff_bank_counter #(
        .WIDTH   (WIDTH),
        .MOD     (MOD),
        .RST_VAL (RST_VAL)
    ) dut (
        .ck  (ck),
        .rs  (rs),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int m_q   = 0;
    int m_tc  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic m, input logic [WIDTH-1:0] tt,
                         input logic u, input logic l, input logic [WIDTH-1:0] dd);
        rs       = r;
        bus.mode = m;
        bus.t    = tt;
        bus.up   = u;
        bus.ld   = l;
        bus.d    = dd;
    endtask

    // Next state straight from the behavioural rules, in plain integers
    task automatic model_step();
        if (rs) begin
            m_q = RST_VAL; m_tc = 0;
        end else if (bus.ld) begin
            m_tc = 0;
            m_q  = bus.mode ? (int'(bus.d) % MOD) : int'(bus.d);
        end else if (!bus.mode) begin
            m_q  = m_q ^ int'(bus.t);
            m_tc = 0;
        end else if (!bus.t[0]) begin
            m_tc = 0;
        end else if (bus.up) begin
            if (m_q >= MOD - 1) begin
                m_tc = 1; m_q = SAT ? MOD - 1 : 0;
            end else begin
                m_tc = 0; m_q = m_q + 1;
            end
        end else begin
            if (m_q >= MOD) begin
                m_tc = 1; m_q = MOD - 1;
            end else if (m_q == 0) begin
                m_tc = 1; m_q = SAT ? 0 : MOD - 1;
            end else begin
                m_tc = 0; m_q = m_q - 1;
            end
        end
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge ck);
        #1;
        check({tag, ".q"},  32'(bus.q),  32'(m_q));
        check({tag, ".tc"}, 32'(bus.tc), 32'(m_tc));
    endtask

    initial begin
        // reset dominates load/count, then hold with t=0
        drive(1'b1, 1'b1, 4'hF, 1'b1, 1'b1, 4'd7);
        repeat (2) cycle("reset");
        check("reset_q_const", 32'(bus.q), 32'(RST_VAL));
        drive(1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 4'd0);
        repeat (5) cycle("hold");

        // toggle bank
        drive(1'b0, 1'b0, 4'b0101, 1'b0, 1'b0, 4'd0);
        cycle("tog1");
        check("tog1_const", 32'(bus.q), 32'd5);
        bus.t = 4'b0011;
        cycle("tog2");
        check("tog2_const", 32'(bus.q), 32'd6);
        bus.t = 4'b0000;
        repeat (2) cycle("tog_hold");

        // up-count across the wrap
        drive(1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 4'd0);
        cycle("ld0");
        drive(1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 4'd0);
        repeat (12) cycle("up");

        // down-count across the wrap
        drive(1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 4'd1);
        cycle("ld1");
        drive(1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 4'd0);
        repeat (3) cycle("down");

        // load beats count and is reduced mod MOD; reset beats load
        drive(1'b0, 1'b1, 4'h1, 1'b1, 1'b1, 4'd13);
        cycle("ld13");
        check("ld13_const", 32'(bus.q), 32'd3);
        drive(1'b1, 1'b1, 4'h1, 1'b1, 1'b1, 4'd13);
        cycle("rs_ld");

        // out-of-range value carried into counter mode
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'd12);
        cycle("ld12");
        drive(1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 4'd0);
        repeat (2) cycle("oor_hold");
        check("oor_hold_const", 32'(bus.q), 32'd12);
        bus.t = 4'h1;
        cycle("oor_up");

        // out-of-range entering a down-count
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'd15);
        cycle("ld15");
        drive(1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 4'd0);
        repeat (2) cycle("oor_down");

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 3) != 0),
                  WIDTH'($urandom),
                  1'($urandom),
                  ($urandom_range(0, 9) == 0),
                  WIDTH'($urandom));
            cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
